// File: rtl/ucsbece152a_taillight_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ucsbece152a_taillight_decoder
// Description : Receive-side decoder for the 6-lamp taillight bus. On every
//               controller step strobe it classifies the transition between
//               the previous and current lamp pattern. It reports a lighting
//               mode (idle/left/right/hazard) once the same class has been
//               seen LOCK_STEPS times in a row. It also reports a brake flag
//               and pulses an error on an illegal step taken while locked.
//
// Ports       : clk       - sole clock, rising edge
//               rst       - synchronous active-high reset
//               step_i    - one-cycle strobe, one controller FSM step
//               lights_i  - lamp bus, [5:3] left lamps, [2:0] right lamps
//               mode_o    - 0 UNKNOWN, 1 IDLE, 2 LEFT, 3 RIGHT, 4 HAZARD
//               brake_o   - brake seen on the last evaluated step
//               locked_o  - a mode has been confirmed
//               error_o   - one-cycle pulse on an illegal step while locked
//
// Parameters  : LOCK_STEPS - consecutive same-class steps needed for lock
//               FILT_LEN   - clocks a lamp must stay high to count as lit
//
// Build macro : UCSBECE152A_TAILLIGHT_DIMMER_FILTER_EN
//               When defined, each lamp bit passes through a FILT_LEN-deep
//               all-ones filter that rejects the running-light dimmer square
//               wave. When undefined, the lamp bus is used directly.
//
// Revision    : 1.0 - initial release
// ============================================================================
module ucsbece152a_taillight_decoder #(
  parameter int LOCK_STEPS = 3,
  parameter int FILT_LEN   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step_i,
  input  logic [5:0] lights_i,
  output logic [2:0] mode_o,
  output logic       brake_o,
  output logic       locked_o,
  output logic       error_o
);

  localparam int CNT_W = (LOCK_STEPS < 1) ? 1 : $clog2(LOCK_STEPS + 1);
  localparam logic [CNT_W-1:0] CNT_LOCK = CNT_W'(LOCK_STEPS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [2:0] MODE_UNKNOWN = 3'd0;
  localparam logic [2:0] MODE_IDLE    = 3'd1;
  localparam logic [2:0] MODE_LEFT    = 3'd2;
  localparam logic [2:0] MODE_RIGHT   = 3'd3;
  localparam logic [2:0] MODE_HAZARD  = 3'd4;

  localparam logic [5:0] ALL_OFF = 6'b000000;
  localparam logic [5:0] ALL_ON  = 6'b111111;

  // Step classes; HOLD_OFF is the reset candidate so that an idle bus
  // locks after exactly LOCK_STEPS quiet steps.
  typedef enum logic [2:0] {
    CLS_HOLD_OFF = 3'd0,
    CLS_HOLD_ON  = 3'd1,
    CLS_LEFT     = 3'd2,
    CLS_RIGHT    = 3'd3,
    CLS_HAZ      = 3'd4,
    CLS_ILLEGAL  = 3'd5
  } step_class_t;

  // --------------------------------------------------------------------------
  // Lamp filter
  // --------------------------------------------------------------------------
  logic [5:0] filt;

`ifdef UCSBECE152A_TAILLIGHT_DIMMER_FILTER_EN
  // A bit counts as lit only when the last FILT_LEN clock samples were all
  // high. The dimmer square wave drops low at least once per FILT_LEN clocks,
  // so dimmed lamps never qualify.
  for (genvar i = 0; i < 6; i++) begin : g_filt
    logic [FILT_LEN-1:0] hist;

    if (FILT_LEN == 1) begin : g_single
      always_ff @(posedge clk) begin
        if (rst) begin
          hist <= '0;
        end else begin
          hist <= lights_i[i];
        end
      end
    end else begin : g_deep
      always_ff @(posedge clk) begin
        if (rst) begin
          hist <= '0;
        end else begin
          hist <= {hist[FILT_LEN-2:0], lights_i[i]};
        end
      end
    end

    assign filt[i] = &hist;
  end
`else
  assign filt = lights_i;
`endif

  // --------------------------------------------------------------------------
  // Transition helpers
  // --------------------------------------------------------------------------
  // Left half lights outward 000 -> 001 -> 011 -> 111 -> 000.
  function automatic logic left_adv(input logic [2:0] from, input logic [2:0] to);
    logic ok;
    ok = 1'b0;
    case (from)
      3'b000:  ok = (to == 3'b001);
      3'b001:  ok = (to == 3'b011);
      3'b011:  ok = (to == 3'b111);
      3'b111:  ok = (to == 3'b000);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Right half lights outward 000 -> 100 -> 110 -> 111 -> 000.
  function automatic logic right_adv(input logic [2:0] from, input logic [2:0] to);
    logic ok;
    ok = 1'b0;
    case (from)
      3'b000:  ok = (to == 3'b100);
      3'b100:  ok = (to == 3'b110);
      3'b110:  ok = (to == 3'b111);
      3'b111:  ok = (to == 3'b000);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // The idle half of a turn sequence must be steady fully off or fully on
  // (on meaning brake).
  function automatic logic half_steady(input logic [2:0] from, input logic [2:0] to);
    return (from == to) && ((from == 3'b000) || (from == 3'b111));
  endfunction

  function automatic logic [2:0] class_to_mode(input step_class_t cls);
    logic [2:0] m;
    case (cls)
      CLS_LEFT:     m = MODE_LEFT;
      CLS_RIGHT:    m = MODE_RIGHT;
      CLS_HAZ:      m = MODE_HAZARD;
      CLS_HOLD_OFF: m = MODE_IDLE;
      CLS_HOLD_ON:  m = MODE_IDLE;
      default:      m = MODE_UNKNOWN;
    endcase
    return m;
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [5:0]       prev;
  step_class_t      cand;
  logic [CNT_W-1:0] cnt;

  // --------------------------------------------------------------------------
  // Step classification
  // --------------------------------------------------------------------------
  step_class_t cls;

  always_comb begin
    cls = CLS_ILLEGAL;
    if ((prev == ALL_OFF) && (filt == ALL_OFF)) begin
      cls = CLS_HOLD_OFF;
    end else if ((prev == ALL_ON) && (filt == ALL_ON)) begin
      cls = CLS_HOLD_ON;
    end else if (((prev == ALL_OFF) && (filt == ALL_ON)) ||
                 ((prev == ALL_ON)  && (filt == ALL_OFF))) begin
      cls = CLS_HAZ;
    end else if (left_adv(prev[5:3], filt[5:3]) &&
                 half_steady(prev[2:0], filt[2:0])) begin
      cls = CLS_LEFT;
    end else if (right_adv(prev[2:0], filt[2:0]) &&
                 half_steady(prev[5:3], filt[5:3])) begin
      cls = CLS_RIGHT;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state evaluation for a step
  // --------------------------------------------------------------------------
  step_class_t      cand_next;
  logic [CNT_W-1:0] cnt_next;
  logic             locked_next;
  logic [2:0]       mode_next;
  logic             brake_next;
  logic             error_next;

  always_comb begin
    cand_next = cand;
    cnt_next  = cnt;

    if (cls == CLS_ILLEGAL) begin
      cnt_next = '0;
    end else if (cls == cand) begin
      if (cnt != CNT_LOCK) begin
        cnt_next = cnt + CNT_ONE;
      end
    end else begin
      // A legal change of class restarts qualification without an error.
      cand_next = cls;
      cnt_next  = CNT_ONE;
    end

    locked_next = (cls != CLS_ILLEGAL) && (cnt_next == CNT_LOCK);
    mode_next   = locked_next ? class_to_mode(cls) : MODE_UNKNOWN;
    error_next  = (cls == CLS_ILLEGAL) && locked_o;

    case (cls)
      CLS_LEFT:    brake_next = (filt[2:0] == 3'b111);
      CLS_RIGHT:   brake_next = (filt[5:3] == 3'b111);
      CLS_HOLD_ON: brake_next = 1'b1;
      default:     brake_next = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      prev     <= ALL_OFF;
      cand     <= CLS_HOLD_OFF;
      cnt      <= '0;
      mode_o   <= MODE_UNKNOWN;
      brake_o  <= 1'b0;
      locked_o <= 1'b0;
      error_o  <= 1'b0;
    end else begin
      error_o <= 1'b0;
      if (step_i) begin
        prev     <= filt;
        cand     <= cand_next;
        cnt      <= cnt_next;
        mode_o   <= mode_next;
        brake_o  <= brake_next;
        locked_o <= locked_next;
        error_o  <= error_next;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ucsbece152a_taillight_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ucsbece152a_taillight_decoder
// Description : Directed self-checking bench for the taillight decoder.
//               Observed outputs are packed as {mode, brake, locked, error}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ucsbece152a_taillight_decoder;

  logic       clk;
  logic       rst;
  logic       step_i;
  logic [5:0] base;
  logic       tog;
  logic       dim_on;
  logic [5:0] lights;
  logic [2:0] mode_o;
  logic       brake_o;
  logic       locked_o;
  logic       error_o;
  logic [5:0] obs;

  int total;
  int bad;

  // Unlit lamps are optionally driven with a dimmer square wave.
  assign lights = base | (dim_on ? ({6{tog}} & ~base) : 6'b000000);
  assign obs    = {mode_o, brake_o, locked_o, error_o};

  ucsbece152a_taillight_decoder dut (
    .clk      (clk),
    .rst      (rst),
    .step_i   (step_i),
    .lights_i (lights),
    .mode_o   (mode_o),
    .brake_o  (brake_o),
    .locked_o (locked_o),
    .error_o  (error_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial tog = 1'b0;
  always @(negedge clk) tog = ~tog;

  task automatic apply_reset;
    rst    = 1'b1;
    step_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Present a pattern long enough for the filter to settle, then strobe once.
  // Returns 1 time unit after the sampling edge.
  task automatic do_step(input logic [5:0] p);
    base = p;
    repeat (6) @(posedge clk);
    #1 step_i = 1'b1;
    @(posedge clk);
    #1 step_i = 1'b0;
  endtask

  task automatic test_reset;
    base   = 6'b101010;
    rst    = 1'b1;
    step_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (obs !== 6'b000_000) begin
      bad++; $display("FAIL reset_outputs got=%b want=%b", obs, 6'b000_000);
    end
    rst = 1'b0; step_i = 1'b0; base = 6'b000000;
  endtask

  task automatic test_left_lock;
    apply_reset();
    do_step(6'b001000);
    total++;
    if (obs !== 6'b000_000) begin
      bad++; $display("FAIL left_step1 got=%b want=%b", obs, 6'b000_000);
    end
    do_step(6'b011000);
    total++;
    if (obs !== 6'b000_000) begin
      bad++; $display("FAIL left_step2_not_locked got=%b want=%b", obs, 6'b000_000);
    end
    do_step(6'b111000);
    total++;
    if (obs !== {3'd2, 3'b010}) begin
      bad++; $display("FAIL left_step3_lock got=%b want=%b", obs, {3'd2, 3'b010});
    end
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (obs !== {3'd2, 3'b010}) begin
      bad++; $display("FAIL left_hold_no_step got=%b want=%b", obs, {3'd2, 3'b010});
    end
  endtask

  // Continues from the left lock, whose last pattern is 111000.
  task automatic test_right_brake;
    do_step(6'b111100);
    total++;
    if (obs !== 6'b000_100) begin
      bad++; $display("FAIL right_step1_unlock got=%b want=%b", obs, 6'b000_100);
    end
    do_step(6'b111110);
    total++;
    if (obs !== 6'b000_100) begin
      bad++; $display("FAIL right_step2 got=%b want=%b", obs, 6'b000_100);
    end
    do_step(6'b111111);
    total++;
    if (obs !== {3'd3, 3'b110}) begin
      bad++; $display("FAIL right_step3_lock got=%b want=%b", obs, {3'd3, 3'b110});
    end
    do_step(6'b111000);
    total++;
    if (obs !== {3'd3, 3'b110}) begin
      bad++; $display("FAIL right_step4_hold got=%b want=%b", obs, {3'd3, 3'b110});
    end
  endtask

  task automatic test_hazard_violation;
    apply_reset();
    do_step(6'b111111);
    do_step(6'b000000);
    total++;
    if (obs !== 6'b000_000) begin
      bad++; $display("FAIL haz_step2 got=%b want=%b", obs, 6'b000_000);
    end
    do_step(6'b111111);
    total++;
    if (obs !== {3'd4, 3'b010}) begin
      bad++; $display("FAIL haz_lock got=%b want=%b", obs, {3'd4, 3'b010});
    end
    do_step(6'b011000);
    total++;
    if (obs !== 6'b000_001) begin
      bad++; $display("FAIL haz_violation_pulse got=%b want=%b", obs, 6'b000_001);
    end
    @(posedge clk);
    #1;
    total++;
    if (obs !== 6'b000_000) begin
      bad++; $display("FAIL error_one_cycle got=%b want=%b", obs, 6'b000_000);
    end
  endtask

  // Continues from the violation above: a second illegal step while unlocked.
  task automatic test_back_to_back;
    do_step(6'b001000);
    total++;
    if (obs !== 6'b000_000) begin
      bad++; $display("FAIL second_illegal_no_pulse got=%b want=%b", obs, 6'b000_000);
    end
  endtask

  task automatic test_idle_brake;
    apply_reset();
    do_step(6'b000000);
    do_step(6'b000000);
    total++;
    if (obs !== 6'b000_000) begin
      bad++; $display("FAIL idle_step2 got=%b want=%b", obs, 6'b000_000);
    end
    do_step(6'b000000);
    total++;
    if (obs !== {3'd1, 3'b010}) begin
      bad++; $display("FAIL idle_lock got=%b want=%b", obs, {3'd1, 3'b010});
    end
    do_step(6'b111111);
    total++;
    if (obs !== 6'b000_000) begin
      bad++; $display("FAIL idle_to_haz_unlock got=%b want=%b", obs, 6'b000_000);
    end
    do_step(6'b111111);
    do_step(6'b111111);
    total++;
    if (obs !== 6'b000_100) begin
      bad++; $display("FAIL brake_step2 got=%b want=%b", obs, 6'b000_100);
    end
    do_step(6'b111111);
    total++;
    if (obs !== {3'd1, 3'b110}) begin
      bad++; $display("FAIL steady_brake_lock got=%b want=%b", obs, {3'd1, 3'b110});
    end
  endtask

  task automatic test_dimmer;
`ifdef UCSBECE152A_TAILLIGHT_DIMMER_FILTER_EN
    dim_on = 1'b1;
`endif
    apply_reset();
    do_step(6'b001000);
    total++;
    if (obs !== 6'b000_000) begin
      bad++; $display("FAIL dim_step1 got=%b want=%b", obs, 6'b000_000);
    end
    do_step(6'b011000);
    do_step(6'b111000);
    total++;
    if (obs !== {3'd2, 3'b010}) begin
      bad++; $display("FAIL dim_left_lock got=%b want=%b", obs, {3'd2, 3'b010});
    end
  endtask

  // Continues from the locked left sequence, dimmer still active if built in.
  task automatic test_reset_mid;
    base = 6'b000000;
    repeat (6) @(posedge clk);
    #1 step_i = 1'b1; rst = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (obs !== 6'b000_000) begin
      bad++; $display("FAIL rst_over_step got=%b want=%b", obs, 6'b000_000);
    end
    step_i = 1'b0; rst = 1'b0;
    do_step(6'b001000);
    total++;
    if (obs !== 6'b000_000) begin
      bad++; $display("FAIL rst_discard_progress got=%b want=%b", obs, 6'b000_000);
    end
    do_step(6'b011000);
    do_step(6'b111000);
    total++;
    if (obs !== {3'd2, 3'b010}) begin
      bad++; $display("FAIL rst_relock got=%b want=%b", obs, {3'd2, 3'b010});
    end
    dim_on = 1'b0;
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    rst    = 1'b1;
    step_i = 1'b0;
    base   = 6'b000000;
    dim_on = 1'b0;

    test_reset();
    test_left_lock();
    test_right_brake();
    test_hazard_violation();
    test_back_to_back();
    test_idle_brake();
    test_dimmer();
    test_reset_mid();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
